draw_sequencer: RTL and testbench
=================================

// Module: draw_sequencer
// PURPOSE
//  Per-frame scheduler for the shared VGA plot port. On each frame tick it launches N drawer
//  clients in fixed priority order (client 0 first, e.g. erase pass, then sprites), one at a time.
//  It pulses each client's go, waits for its done, and routes only the active client's
//  x/y/color/plot to the VGA adaptor through a registered mux. Sits between drawers and vga_adapter.
// PARAMETERS
//  N_CLIENTS  4      number of drawer clients (2..8)
//  X_W        9      x coordinate width
//  Y_W        8      y coordinate width
//  C_W        3      colour width
//  TIMEOUT    65535  max cycles a client may run before abort (fits 17-bit counter)
// PORTS
//  clk         in   1              system clock
//  reset       in   1              asynchronous, active-high reset
//  frame_tick  in   1              single-cycle frame strobe (sixty_signal)
//  client_en   in   N_CLIENTS      per-client enable, sampled on accepted frame_tick
//  client_done in   N_CLIENTS      per-client done pulse/level
//  client_plot in   N_CLIENTS      per-client plot strobe
//  client_x    in   N_CLIENTS*X_W  packed x, client i at [i*X_W +: X_W]
//  client_y    in   N_CLIENTS*Y_W  packed y
//  client_col  in   N_CLIENTS*C_W  packed colour
//  client_go   out  N_CLIENTS      one-cycle go pulse to the launched client
//  x_out       out  X_W            registered x to VGA
//  y_out       out  Y_W            registered y to VGA
//  color_out   out  C_W            registered colour to VGA
//  plot_out    out  1              registered plot to VGA
//  busy        out  1              high from accepted tick until last client finishes
//  frame_done  out  1              one-cycle pulse when the frame's sequence completes
//  overrun     out  1              one-cycle pulse: frame_tick arrived while busy
//  timeout_err out  1              sticky; set on any client abort, cleared by reset only
// BEHAVIOUR
//  - Reset: state IDLE, idx=0, mask=0, all outputs 0, timer=0.
//  - States: IDLE -> SCAN -> LAUNCH -> WAIT -> SCAN ... -> FINISH -> IDLE.
//  - IDLE: on frame_tick, latch mask<=client_en, idx<=0, busy<=1, go to SCAN. Otherwise hold.
//  - SCAN: if mask[idx], go to LAUNCH; else if idx==N_CLIENTS-1, go to FINISH;
//    else idx++ (one cycle per skipped client).
//  - LAUNCH: client_go[idx]=1 for exactly this cycle; timer<=0; go to WAIT.
//  - WAIT: route client idx to outputs; timer++. Leave WAIT on client_done[idx]==1, or on
//    timer==TIMEOUT-1 (set timeout_err). Then: idx==N_CLIENTS-1 ? FINISH : (idx++, SCAN).
//    done is ignored in LAUNCH, so a level left high from a previous frame is not
//    misread as completion.
//  - FINISH: frame_done=1 for one cycle, busy<=0, go to IDLE.
//  - Output mux: x/y/color/plot_out take client idx's inputs one clock after sampling.
//    plot_out is forced 0 in every state except WAIT, including the done/abort cycle.
//    x/y/color_out hold their last value otherwise.
//  - Latency: tick->go of the first enabled client is 2 cycles plus 1 cycle per skipped client.
//    done->go of the next client is 2 cycles plus skips.
//  - frame_tick while busy: pulse overrun, and do not restart the sequence.
//    A tick in the FINISH cycle also counts as an overrun.
//  - client_en==0 at the tick: SCAN walks to FINISH, frame_done pulses, and no go is issued.
//  - Done from a non-active client is ignored. client_en changes mid-frame have no effect.
//  - Async reset mid-frame: all outputs 0 immediately; clients are not notified.
// STRUCTURE
//  - Shared package draw_pkg: X_W/Y_W/C_W defaults and a state enum {S_IDLE,S_SCAN,
//    S_LAUNCH,S_WAIT,S_FINISH}, for reuse by other screen controllers.
//  - One sub-module, plot_mux: registered N:1 selector for x/y/color/plot with plot gating.
//    FSM, idx, mask and timer stay in the top.
// TESTING
//  1 en=4'b1111, each client done 10 cycles after go -> go pulses in order 0,1,2,3;
//    frame_done 1 cycle after the FINISH entry; busy high throughout.
//  2 en=4'b0101 -> go only on clients 0 and 2; client 1 go stays 0; no plot from 1/3 reaches VGA.
//  3 en=0 at tick -> no go, frame_done pulses 2+N cycles after tick, plot_out stays 0.
//  4 Client 1 never asserts done, TIMEOUT=16 -> abort after 16 WAIT cycles, timeout_err=1,
//    client 2 launched.
//  5 Second frame_tick while client 0 active -> overrun pulse, sequence unchanged,
//    single frame_done.
//  6 reset asserted during WAIT of client 2 -> plot_out/busy/go=0 same cycle;
//    next tick restarts from client 0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared definitions for the screen-drawing controllers: default pixel field widths,
// the frame sequencer state encoding and a small index-width helper.
package draw_pkg;

  localparam int DEF_X_W = 9;
  localparam int DEF_Y_W = 8;
  localparam int DEF_C_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } draw_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/draw_sequencer_plot_mux.sv
// Registered N:1 selector that forwards one drawer client's pixel to the VGA port.
// Plot is only passed while routing is enabled; coordinates and colour hold otherwise.
module plot_mux
  import draw_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int C_W       = DEF_C_W,
  parameter int IDX_W     = idx_width(N_CLIENTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     route,
  input  logic [IDX_W-1:0]         sel,
  input  logic [N_CLIENTS-1:0]     client_plot,
  input  logic [N_CLIENTS*X_W-1:0] client_x,
  input  logic [N_CLIENTS*Y_W-1:0] client_y,
  input  logic [N_CLIENTS*C_W-1:0] client_col,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [C_W-1:0]           color_out,
  output logic                     plot_out
);

  logic [X_W-1:0] x_sel;
  logic [Y_W-1:0] y_sel;
  logic [C_W-1:0] c_sel;
  logic           p_sel;

  always_comb begin
    x_sel = client_x[int'(sel)*X_W +: X_W];
    y_sel = client_y[int'(sel)*Y_W +: Y_W];
    c_sel = client_col[int'(sel)*C_W +: C_W];
    p_sel = client_plot[sel];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_out     <= '0;
      y_out     <= '0;
      color_out <= '0;
      plot_out  <= 1'b0;
    end else begin
      plot_out <= route & p_sel;
      if (route) begin
        x_out     <= x_sel;
        y_out     <= y_sel;
        color_out <= c_sel;
      end
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Per-frame scheduler for the shared VGA plot port: launches enabled drawer clients
// one at a time in index order and routes the active one's pixels to the adaptor.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int N_CLIENTS = 4,
  parameter int X_W       = DEF_X_W,
  parameter int Y_W       = DEF_Y_W,
  parameter int C_W       = DEF_C_W,
  parameter int TIMEOUT   = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic [N_CLIENTS-1:0]     client_en,
  input  logic [N_CLIENTS-1:0]     client_done,
  input  logic [N_CLIENTS-1:0]     client_plot,
  input  logic [N_CLIENTS*X_W-1:0] client_x,
  input  logic [N_CLIENTS*Y_W-1:0] client_y,
  input  logic [N_CLIENTS*C_W-1:0] client_col,
  output logic [N_CLIENTS-1:0]     client_go,
  output logic [X_W-1:0]           x_out,
  output logic [Y_W-1:0]           y_out,
  output logic [C_W-1:0]           color_out,
  output logic                     plot_out,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overrun,
  output logic                     timeout_err
);

  localparam int IDX_W   = idx_width(N_CLIENTS);
  localparam int TIMER_W = 17;
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_CLIENTS - 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

  draw_state_t          state, state_nx;
  logic [IDX_W-1:0]     idx, idx_nx;
  logic [N_CLIENTS-1:0] mask, mask_nx;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic                 busy_nx;
  logic                 err_nx;
  logic                 leave;
  logic                 route;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      mask        <= '0;
      timer       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_nx;
      idx         <= idx_nx;
      mask        <= mask_nx;
      timer       <= timer_nx;
      busy        <= busy_nx;
      timeout_err <= err_nx;
      frame_done  <= (state == S_FINISH);
      overrun     <= frame_tick && (state != S_IDLE);
    end
  end

  // Done is only looked at in WAIT, so a level still high from the previous
  // frame cannot complete a client during its LAUNCH cycle.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    mask_nx   = mask;
    timer_nx  = timer;
    busy_nx   = busy;
    err_nx    = timeout_err;
    client_go = '0;
    leave     = 1'b0;
    route     = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_tick) begin
          mask_nx  = client_en;
          idx_nx   = '0;
          busy_nx  = 1'b1;
          state_nx = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask[idx]) begin
          state_nx = S_LAUNCH;
        end else if (idx == LAST_IDX) begin
          state_nx = S_FINISH;
        end else begin
          idx_nx = idx + 1'b1;
        end
      end
      S_LAUNCH: begin
        client_go[idx] = 1'b1;
        timer_nx       = '0;
        state_nx       = S_WAIT;
      end
      S_WAIT: begin
        timer_nx = timer + 1'b1;
        leave    = client_done[idx] || (timer == TIMER_MAX);
        route    = !leave;
        if (leave) begin
          if (!client_done[idx]) begin
            err_nx = 1'b1;
          end
          if (idx == LAST_IDX) begin
            state_nx = S_FINISH;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = S_SCAN;
          end
        end
      end
      S_FINISH: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  plot_mux #(
    .N_CLIENTS (N_CLIENTS),
    .X_W       (X_W),
    .Y_W       (Y_W),
    .C_W       (C_W),
    .IDX_W     (IDX_W)
  ) u_plot_mux (
    .clk         (clk),
    .reset       (reset),
    .route       (route),
    .sel         (idx),
    .client_plot (client_plot),
    .client_x    (client_x),
    .client_y    (client_y),
    .client_col  (client_col),
    .x_out       (x_out),
    .y_out       (y_out),
    .color_out   (color_out),
    .plot_out    (plot_out)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized bench for draw_sequencer: each scenario's timeline is derived from the
// frame schedule rules, then replayed cycle by cycle against the DUT outputs.
module tb_draw_sequencer;

  localparam int N      = 4;
  localparam int XW     = 9;
  localparam int YW     = 8;
  localparam int CW     = 3;
  localparam int TO     = 16;
  localparam int MAXC   = 256;
  localparam int T_TICK = 2;

  logic          clk         = 1'b0;
  logic          reset       = 1'b1;
  logic          frame_tick  = 1'b0;
  logic [N-1:0]  client_en   = '0;
  logic [N-1:0]  client_done = '0;
  logic [N-1:0]  client_plot = '0;
  logic [N*XW-1:0] client_x  = '0;
  logic [N*YW-1:0] client_y  = '0;
  logic [N*CW-1:0] client_col = '0;
  logic [N-1:0]  client_go;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] color_out;
  logic          plot_out;
  logic          busy;
  logic          frame_done;
  logic          overrun;
  logic          timeout_err;

  draw_sequencer #(
    .N_CLIENTS (N),
    .X_W       (XW),
    .Y_W       (YW),
    .C_W       (CW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .client_en   (client_en),
    .client_done (client_done),
    .client_plot (client_plot),
    .client_x    (client_x),
    .client_y    (client_y),
    .client_col  (client_col),
    .client_go   (client_go),
    .x_out       (x_out),
    .y_out       (y_out),
    .color_out   (color_out),
    .plot_out    (plot_out),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int scen  = 0;
  int cyc   = 0;

  logic            st_tick [MAXC];
  logic            st_rst  [MAXC];
  logic [N-1:0]    st_en   [MAXC];
  logic [N-1:0]    st_done [MAXC];
  logic [N-1:0]    st_plot [MAXC];
  logic [N*XW-1:0] st_x    [MAXC];
  logic [N*YW-1:0] st_y    [MAXC];
  logic [N*CW-1:0] st_col  [MAXC];

  logic [N-1:0]  ex_go   [MAXC];
  logic          ex_busy [MAXC];
  logic          ex_fd   [MAXC];
  logic          ex_ov   [MAXC];
  logic          ex_plot [MAXC];
  logic          ex_err  [MAXC];
  logic [XW-1:0] ex_x    [MAXC];
  logic [YW-1:0] ex_y    [MAXC];
  logic [CW-1:0] ex_col  [MAXC];

  logic          up_v    [MAXC];
  logic [XW-1:0] up_x    [MAXC];
  logic [YW-1:0] up_y    [MAXC];
  logic [CW-1:0] up_c    [MAXC];
  logic          err_set [MAXC];

  int k_plan [N];
  int go_at  [N];

  logic [XW-1:0] hold_x   = '0;
  logic [YW-1:0] hold_y   = '0;
  logic [CW-1:0] hold_c   = '0;
  logic          hold_err = 1'b0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s scen=%0d cyc=%0d got=%0h expected=%0h", tag, scen, cyc, got, exp);
    end
  endtask

  // k_plan[i] = WAIT cycles before client i raises done; >= TO means it never does.
  task automatic planScenario(input logic [N-1:0] en, input int extra_mode,
                              input int reset_mode, output int win);
    int t;
    int last;
    int fin;
    int x_at;
    int r_at;
    for (int c = 0; c < MAXC; c++) begin
      st_tick[c] = 1'b0;
      st_rst[c]  = 1'b0;
      st_en[c]   = N'($urandom());
      st_done[c] = N'($urandom() & $urandom() & $urandom());
      st_plot[c] = N'($urandom());
      st_x[c]    = (N*XW)'({$urandom(), $urandom()});
      st_y[c]    = (N*YW)'($urandom());
      st_col[c]  = (N*CW)'($urandom());
      ex_go[c]   = '0;
      ex_busy[c] = 1'b0;
      ex_fd[c]   = 1'b0;
      ex_ov[c]   = 1'b0;
      ex_plot[c] = 1'b0;
      up_v[c]    = 1'b0;
      up_x[c]    = '0;
      up_y[c]    = '0;
      up_c[c]    = '0;
      err_set[c] = 1'b0;
    end
    st_tick[T_TICK] = 1'b1;
    st_en[T_TICK]   = en;
    t = T_TICK + 1;
    for (int i = 0; i < N; i++) begin
      go_at[i] = -1;
      if (en[i]) begin
        go_at[i] = t + 1;
        ex_go[t+1][i] = 1'b1;
        st_done[t+1][i] = 1'($urandom_range(0, 1));
        last = t + 2 + ((k_plan[i] < TO) ? k_plan[i] : TO - 1);
        for (int c = t + 2; c <= last; c++) st_done[c][i] = 1'b0;
        if (k_plan[i] < TO) st_done[t+2+k_plan[i]][i] = 1'b1;
        else err_set[last+1] = 1'b1;
        for (int c = t + 2; c < last; c++) begin
          up_v[c+1]    = 1'b1;
          up_x[c+1]    = st_x[c][i*XW +: XW];
          up_y[c+1]    = st_y[c][i*YW +: YW];
          up_c[c+1]    = st_col[c][i*CW +: CW];
          ex_plot[c+1] = st_plot[c][i];
        end
        t = last + 1;
      end else begin
        t = t + 1;
      end
    end
    fin = t;
    for (int c = T_TICK + 1; c <= fin; c++) ex_busy[c] = 1'b1;
    ex_fd[fin+1] = 1'b1;
    x_at = -1;
    if (extra_mode == 1) x_at = int'($urandom_range(T_TICK + 1, fin));
    if (extra_mode == 2) x_at = go_at[0] + 3;
    if (x_at >= 0) begin
      st_tick[x_at]  = 1'b1;
      ex_ov[x_at+1]  = 1'b1;
    end
    r_at = -1;
    if (reset_mode == 1) r_at = int'($urandom_range(T_TICK, fin));
    if (reset_mode == 2) r_at = go_at[2] + 3;
    if (r_at >= 0) begin
      st_rst[r_at] = 1'b1;
      win = r_at + 3;
    end else begin
      win = fin + 4;
    end
    for (int c = 0; c < win; c++) begin
      if (r_at >= 0 && c >= r_at) begin
        hold_x = '0; hold_y = '0; hold_c = '0; hold_err = 1'b0;
        ex_go[c] = '0; ex_busy[c] = 1'b0; ex_fd[c] = 1'b0;
        ex_ov[c] = 1'b0; ex_plot[c] = 1'b0;
      end else begin
        if (up_v[c]) begin
          hold_x = up_x[c]; hold_y = up_y[c]; hold_c = up_c[c];
        end
        if (err_set[c]) hold_err = 1'b1;
      end
      ex_x[c]   = hold_x;
      ex_y[c]   = hold_y;
      ex_col[c] = hold_c;
      ex_err[c] = hold_err;
    end
  endtask

  task automatic applyStimulus(input int win);
    for (int c = 0; c < win; c++) begin
      @(posedge clk);
      #1;
      cyc         = c;
      reset       = st_rst[c];
      frame_tick  = st_tick[c];
      client_en   = st_en[c];
      client_done = st_done[c];
      client_plot = st_plot[c];
      client_x    = st_x[c];
      client_y    = st_y[c];
      client_col  = st_col[c];
      @(negedge clk);
      checkOutput("go",         64'(client_go),   64'(ex_go[c]));
      checkOutput("busy",       64'(busy),        64'(ex_busy[c]));
      checkOutput("frame_done", 64'(frame_done),  64'(ex_fd[c]));
      checkOutput("overrun",    64'(overrun),     64'(ex_ov[c]));
      checkOutput("timeout",    64'(timeout_err), 64'(ex_err[c]));
      checkOutput("plot",       64'(plot_out),    64'(ex_plot[c]));
      checkOutput("x",          64'(x_out),       64'(ex_x[c]));
      checkOutput("y",          64'(y_out),       64'(ex_y[c]));
      checkOutput("color",      64'(color_out),   64'(ex_col[c]));
    end
  endtask

  task automatic runScenario(input logic [N-1:0] en, input int extra_mode, input int reset_mode);
    int win;
    planScenario(en, extra_mode, reset_mode, win);
    applyStimulus(win);
  endtask

  task automatic setDelays(input int d);
    for (int i = 0; i < N; i++) k_plan[i] = d;
  endtask

  task automatic randomDelays();
    for (int i = 0; i < N; i++)
      k_plan[i] = ($urandom_range(0, 7) == 0) ? 100 : int'($urandom_range(0, TO - 1));
  endtask

  initial begin
    int em;
    int rm;
    scen = 0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_go",    64'(client_go),   64'(0));
      checkOutput("rst_busy",  64'(busy),        64'(0));
      checkOutput("rst_plot",  64'(plot_out),    64'(0));
      checkOutput("rst_x",     64'(x_out),       64'(0));
      checkOutput("rst_fd",    64'(frame_done),  64'(0));
      checkOutput("rst_err",   64'(timeout_err), 64'(0));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    scen = 1; setDelays(9);                 runScenario(4'b1111, 0, 0);
    scen = 2; randomDelays();               runScenario(4'b0101, 0, 0);
    scen = 3; setDelays(9);                 runScenario(4'b0000, 0, 0);
    scen = 4; setDelays(9); k_plan[1] = 1000; runScenario(4'b1111, 0, 0);
    scen = 5; setDelays(9);                 runScenario(4'b1111, 2, 0);
    scen = 6; setDelays(9);                 runScenario(4'b1111, 0, 2);
    scen = 7; randomDelays();               runScenario(4'b1111, 0, 0);
    scen = 8; setDelays(TO - 1);            runScenario(4'b1001, 0, 0);

    for (int s = 9; s < 49; s++) begin
      scen = s;
      randomDelays();
      em = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rm = (em == 0 && $urandom_range(0, 5) == 0) ? 1 : 0;
      runScenario(N'($urandom()), em, rm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
